// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, register index
// type and a width helper for the small internal counters.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    // Bits needed to hold values 0..max_val (at least one).
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((max_val >> i) != 0) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination is read by the
// instruction in ID. Writes to register zero never create a dependency.
module hazard_detect
    import hazard_pkg::*;
(
    input  reg_idx_t id_rs,
    input  reg_idx_t id_rt,
    input  logic     id_uses_rs,
    input  logic     id_uses_rt,
    input  logic     ex_mem_read,
    input  reg_idx_t ex_rt,
    output logic     load_use
);

    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit = id_uses_rs && (ex_rt == id_rs);
    assign w_rt_hit = id_uses_rt && (ex_rt == id_rt);
    assign load_use = ex_mem_read && (ex_rt != REG_ZERO) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pipeline_controller.sv
// Hazard and sequencing controller for the five-stage pipeline: load-use
// stalls, branch/jump flushes, memory wait states with timeout, HLT drain.
module pipeline_controller
    import hazard_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int MEM_TIMEOUT  = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  reg_idx_t         id_rs,
    input  reg_idx_t         id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             id_hlt,
    input  logic             ex_mem_read,
    input  reg_idx_t         ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_hold,
    output logic             mem_wb_bubble,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_count
);

    localparam int DRAIN_W = cnt_width(DRAIN_CYCLES);
    localparam int WAIT_W  = cnt_width(MEM_TIMEOUT);

    state_t               r_state;
    state_t               w_next_state;
    logic [DRAIN_W-1:0]   r_drain_cnt;
    logic [WAIT_W-1:0]    r_wait_cnt;
    logic                 r_mem_err;
    logic [CNT_W-1:0]     r_stall_count;
    logic                 w_wait;
    logic                 w_lu;
    logic                 w_timeout;
    logic                 w_enter_drain;

    hazard_detect u_hazard_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .load_use    (w_lu)
    );

    assign w_wait        = mem_req && !mem_ready;
    // The wait that would make the counter reach MEM_TIMEOUT is the fatal one.
    assign w_timeout     = w_wait && (r_state != HALTED) &&
                           (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
    assign w_enter_drain = (r_state == RUN) && !w_wait && !ex_branch_taken &&
                           !w_lu && id_hlt;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RUN: begin
                if (w_timeout) begin
                    w_next_state = HALTED;
                end else if (w_enter_drain) begin
                    w_next_state = DRAIN;
                end else begin
                    w_next_state = RUN;
                end
            end
            DRAIN: begin
                if (w_timeout) begin
                    w_next_state = HALTED;
                end else if (!w_wait && (r_drain_cnt == DRAIN_W'(1))) begin
                    w_next_state = HALTED;
                end else begin
                    w_next_state = DRAIN;
                end
            end
            HALTED:  w_next_state = HALTED;
            default: w_next_state = RUN;
        endcase
    end

    // Output decode with RUN-state priority: wait, branch, load-use, HLT, jump.
    always_comb begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        pipe_hold     = 1'b0;
        mem_wb_bubble = 1'b0;
        halted        = 1'b0;
        case (r_state)
            RUN: begin
                if (w_wait) begin
                    pipe_hold     = 1'b1;
                    mem_wb_bubble = 1'b1;
                end else if (ex_branch_taken) begin
                    pc_write      = 1'b1;
                    if_id_flush   = 1'b1;
                    id_ex_bubble  = 1'b1;
                end else if (w_lu || id_hlt) begin
                    id_ex_bubble  = 1'b1;
                end else if (id_jump) begin
                    pc_write      = 1'b1;
                    if_id_flush   = 1'b1;
                end else begin
                    pc_write      = 1'b1;
                    if_id_write   = 1'b1;
                end
            end
            DRAIN: begin
                id_ex_bubble = 1'b1;
                if (w_wait) begin
                    pipe_hold     = 1'b1;
                    mem_wb_bubble = 1'b1;
                end else begin
                    pipe_hold     = 1'b0;
                end
            end
            HALTED: begin
                pipe_hold     = 1'b1;
                id_ex_bubble  = 1'b1;
                mem_wb_bubble = 1'b1;
                halted        = 1'b1;
            end
            default: begin
                pc_write = 1'b0;
            end
        endcase
    end

    // Drain and consecutive-wait counters; a wait cycle freezes the drain count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drain_cnt <= '0;
            r_wait_cnt  <= '0;
        end else begin
            if (w_enter_drain) begin
                r_drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
            end else if ((r_state == DRAIN) && !w_wait && (r_drain_cnt != '0)) begin
                r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
            end else begin
                r_drain_cnt <= r_drain_cnt;
            end
            if (w_wait && (r_state != HALTED) && !w_timeout) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    // Sticky timeout flag and saturating stall-cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_err     <= 1'b0;
            r_stall_count <= '0;
        end else begin
            r_mem_err <= r_mem_err || w_timeout;
            if (!pc_write && (r_state != HALTED) && (r_stall_count != {CNT_W{1'b1}})) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end else begin
                r_stall_count <= r_stall_count;
            end
        end
    end

    assign mem_err     = r_mem_err;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_pipeline_controller;

    localparam int DRAIN = 3;
    localparam int TMO   = 15;
    localparam int CW    = 5;
    localparam int SMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [4:0]    id_rs, id_rt, ex_rt;
    logic          id_uses_rs, id_uses_rt, id_jump, id_hlt;
    logic          ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic          pc_write, if_id_write, if_id_flush, id_ex_bubble;
    logic          pipe_hold, mem_wb_bubble, halted, mem_err;
    logic [CW-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    pipeline_controller #(
        .DRAIN_CYCLES (DRAIN),
        .MEM_TIMEOUT  (TMO),
        .CNT_W        (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_jump         (id_jump),
        .id_hlt          (id_hlt),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .pipe_hold       (pipe_hold),
        .mem_wb_bubble   (mem_wb_bubble),
        .halted          (halted),
        .mem_err         (mem_err),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_jump = 1'b0; id_hlt = 1'b0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    // Reference model: mode 0=running, 1=draining, 2=stopped.
    int m_mode = 0, m_drain_left = 0, m_wait_run = 0, m_err = 0, m_stall = 0;

    initial begin
        logic wt, lu;
        logic e_pc, e_ifw, e_fl, e_bub, e_hold, e_mwb, e_halt;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_mode = 0; m_drain_left = 0; m_wait_run = 0; m_err = 0; m_stall = 0;
            end
            wt = mem_req && !mem_ready;
            lu = ex_mem_read && (ex_rt != 5'd0) &&
                 ((id_uses_rs && ex_rt == id_rs) || (id_uses_rt && ex_rt == id_rt));
            {e_pc, e_ifw, e_fl, e_bub, e_hold, e_mwb, e_halt} = 7'd0;
            if (m_mode == 2) begin
                {e_hold, e_bub, e_mwb, e_halt} = 4'b1111;
            end else if (m_mode == 1) begin
                e_bub = 1'b1;
                {e_hold, e_mwb} = {wt, wt};
            end else if (wt) begin
                {e_hold, e_mwb} = 2'b11;
            end else if (ex_branch_taken) begin
                {e_pc, e_fl, e_bub} = 3'b111;
            end else if (lu || id_hlt) begin
                e_bub = 1'b1;
            end else if (id_jump) begin
                {e_pc, e_fl} = 2'b11;
            end else begin
                {e_pc, e_ifw} = 2'b11;
            end
            chk("ctrl", {24'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble,
                         pipe_hold, mem_wb_bubble, halted, mem_err},
                {24'd0, e_pc, e_ifw, e_fl, e_bub, e_hold, e_mwb, e_halt, m_err[0]});
            chk("stall_count", 32'(stall_count), 32'(m_stall));
            if (!reset && m_mode != 2) begin
                if (!e_pc && m_stall < SMAX) m_stall++;
                if (wt) begin
                    m_wait_run++;
                    if (m_wait_run == TMO) begin
                        m_err = 1;
                        m_mode = 2;
                    end
                end else begin
                    m_wait_run = 0;
                    if (m_mode == 0 && !ex_branch_taken && !lu && id_hlt) begin
                        m_mode = 1;
                        m_drain_left = DRAIN;
                    end else if (m_mode == 1) begin
                        m_drain_left--;
                        if (m_drain_left == 0) m_mode = 2;
                    end
                end
            end
        end
    end

    initial begin
        idle();
        do_reset();
        #3;
        chk("reset_pc_write", 32'(pc_write), 32'd1);
        chk("reset_if_id_write", 32'(if_id_write), 32'd1);
        chk("reset_stall_count", 32'(stall_count), 32'd0);
        cyc();

        // Load-use stall, then same pattern with ex_rt = 0.
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
        #3;
        chk("lu_pc_write", 32'(pc_write), 32'd0);
        chk("lu_if_id_write", 32'(if_id_write), 32'd0);
        chk("lu_bubble", 32'(id_ex_bubble), 32'd1);
        cyc();
        idle();
        #3;
        chk("lu_stall_count", 32'(stall_count), 32'd1);
        cyc();
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        #3;
        chk("lu_r0_pc_write", 32'(pc_write), 32'd1);
        cyc();

        // Taken branch overrides load-use and HLT.
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
        id_hlt = 1'b1; ex_branch_taken = 1'b1;
        #3;
        chk("br_flush", 32'(if_id_flush), 32'd1);
        chk("br_bubble", 32'(id_ex_bubble), 32'd1);
        chk("br_pc_write", 32'(pc_write), 32'd1);
        cyc();
        idle();
        #3;
        chk("br_stays_run", 32'(pc_write), 32'd1);
        cyc();

        // Jump.
        id_jump = 1'b1;
        #3;
        chk("jmp_flush", 32'(if_id_flush), 32'd1);
        chk("jmp_pc_write", 32'(pc_write), 32'd1);
        chk("jmp_bubble", 32'(id_ex_bubble), 32'd0);
        cyc();

        // Three memory wait cycles.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            mem_req = 1'b1;
            mem_ready = (k == 3);
            #3;
            chk("wait_hold", 32'(pipe_hold), (k < 3) ? 32'd1 : 32'd0);
            chk("wait_mwb", 32'(mem_wb_bubble), (k < 3) ? 32'd1 : 32'd0);
            cyc();
        end
        idle();
        #3;
        chk("wait_stall_count", 32'(stall_count), 32'd3);
        chk("wait_mem_err", 32'(mem_err), 32'd0);
        cyc();

        // Timeout after 15 continuous wait cycles, cleared by reset.
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int k = 0; k <= TMO; k++) begin
            #3;
            chk("tmo_halted", 32'(halted), (k >= TMO) ? 32'd1 : 32'd0);
            chk("tmo_mem_err", 32'(mem_err), (k >= TMO) ? 32'd1 : 32'd0);
            cyc();
        end
        reset = 1'b1;
        #1;
        chk("tmo_rst_err", 32'(mem_err), 32'd0);
        chk("tmo_rst_halted", 32'(halted), 32'd0);
        do_reset();

        // HLT drain: plain, with one wait cycle, and with reset mid-drain.
        for (int v = 0; v < 3; v++) begin
            do_reset();
            cyc();
            id_hlt = 1'b1;
            #3;
            chk("hlt_bubble", 32'(id_ex_bubble), 32'd1);
            cyc();
            idle();
            for (int k = 1; k <= 5; k++) begin
                if (v == 1 && k == 2) begin
                    mem_req = 1'b1; mem_ready = 1'b0;
                end else begin
                    idle();
                end
                if (v == 2 && k == 2) begin
                    reset = 1'b1;
                    #1;
                    chk("hlt_rst_pc_write", 32'(pc_write), 32'd1);
                    chk("hlt_rst_halted", 32'(halted), 32'd0);
                    cyc();
                    reset = 1'b0;
                    break;
                end
                #3;
                chk("hlt_halted", 32'(halted), (k >= ((v == 1) ? 5 : 4)) ? 32'd1 : 32'd0);
                cyc();
            end
        end

        // Saturation of the stall counter under a held load-use.
        do_reset();
        ex_mem_read = 1'b1; ex_rt = 5'd3; id_rt = 5'd3; id_uses_rt = 1'b1;
        for (int k = 0; k < 40; k++) cyc();
        #3;
        chk("sat_stall_count", 32'(stall_count), 32'(SMAX));
        cyc();

        // Randomized traffic.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            reset           = ($urandom_range(0, 149) == 0);
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            ex_rt           = 5'($urandom_range(0, 3));
            id_uses_rs      = 1'($urandom_range(0, 1));
            id_uses_rt      = 1'($urandom_range(0, 1));
            ex_mem_read     = ($urandom_range(0, 2) == 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            id_jump         = ($urandom_range(0, 7) == 0);
            id_hlt          = ($urandom_range(0, 24) == 0);
            mem_req         = ($urandom_range(0, 2) == 0);
            mem_ready       = (n % 1000 > 900) ? 1'b0 : ($urandom_range(0, 3) != 0);
            cyc();
        end
        reset = 1'b0;
        idle();
        cyc();
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
